// File: rtl/keccak_pkg.sv
// Shared types, constants and lane helpers for the Keccak-f[1600] permutation.
package keccak_pkg;

    localparam int unsigned NUM_ROUNDS  = 24;
    localparam int unsigned LANE_W      = 64;
    localparam int unsigned RC8_W       = 8;
    localparam int unsigned ROUND_IDX_W = 5;

    typedef logic [4:0][4:0][LANE_W-1:0] keccak_state_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } keccak_fsm_t;

    // Compressed round constants {RC[63],RC[31],RC[15],RC[7],RC[3],0,RC[1],RC[0]}
    localparam logic [RC8_W-1:0] RC8_TABLE [NUM_ROUNDS] = '{
        8'h01, 8'h32, 8'hBA, 8'hE0, 8'h3B, 8'h41, 8'hF1, 8'hA9,
        8'h1A, 8'h18, 8'h69, 8'h4A, 8'h7B, 8'h9B, 8'hB9, 8'hA3,
        8'hA2, 8'h90, 8'h2A, 8'hCA, 8'hF1, 8'hB0, 8'h41, 8'hE8
    };

    // Rho rotation offsets indexed [y][x]
    localparam int unsigned RHO_OFS [5][5] = '{
        '{ 0,  1, 62, 28, 27},
        '{36, 44,  6, 55, 20},
        '{ 3, 10, 43, 25, 39},
        '{41, 45, 15, 21,  8},
        '{18,  2, 61, 56, 14}
    };

    function automatic logic [LANE_W-1:0] rotl64(input logic [LANE_W-1:0] v, input int unsigned n);
        if (n == 0) begin
            return v;
        end
        return (v << n) | (v >> (LANE_W - n));
    endfunction

    // rc8 bits land on lane bits 0,1,2,3,7,15,31,63
    function automatic logic [LANE_W-1:0] rc8_expand(input logic [RC8_W-1:0] rc8);
        logic [LANE_W-1:0] r;
        r     = '0;
        r[0]  = rc8[0];
        r[1]  = rc8[1];
        r[2]  = rc8[2];
        r[3]  = rc8[3];
        r[7]  = rc8[4];
        r[15] = rc8[5];
        r[31] = rc8[6];
        r[63] = rc8[7];
        return r;
    endfunction

endpackage

// File: rtl/keccak_rc_gen.sv
// Maps a round index to its compressed 8-bit round constant.
module keccak_rc_gen
    import keccak_pkg::*;
(
    input  logic [ROUND_IDX_W-1:0] i_round,
    output logic [RC8_W-1:0]       o_rc8_c
);

    always_comb begin
        o_rc8_c = '0;
        if (32'(i_round) < NUM_ROUNDS) begin
            o_rc8_c = RC8_TABLE[i_round];
        end
    end

endmodule

// File: rtl/keccak_round.sv
// One combinational Keccak-f[1600] round: theta, rho, pi, chi, iota.
module keccak_round
    import keccak_pkg::*;
(
    input  keccak_state_t    i_state,
    input  logic [RC8_W-1:0] i_rc8,
    output keccak_state_t    o_state_c
);

    logic [4:0][LANE_W-1:0] w_c;
    logic [4:0][LANE_W-1:0] w_d;
    keccak_state_t          w_theta;
    keccak_state_t          w_pi;

    always_comb begin
        w_c       = '0;
        w_d       = '0;
        w_theta   = '0;
        w_pi      = '0;
        o_state_c = '0;
        for (int x = 0; x < 5; x++) begin
            w_c[x] = i_state[0][x] ^ i_state[1][x] ^ i_state[2][x] ^ i_state[3][x] ^ i_state[4][x];
        end
        for (int x = 0; x < 5; x++) begin
            w_d[x] = w_c[(x + 4) % 5] ^ rotl64(w_c[(x + 1) % 5], 1);
        end
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                w_theta[y][x] = i_state[y][x] ^ w_d[x];
            end
        end
        // Lane (x,y) moves to (y, 2x+3y) after its rho rotation
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                w_pi[(2 * x + 3 * y) % 5][y] = rotl64(w_theta[y][x], RHO_OFS[y][x]);
            end
        end
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                o_state_c[y][x] = w_pi[y][x] ^ (~w_pi[y][(x + 1) % 5] & w_pi[y][(x + 2) % 5]);
            end
        end
        o_state_c[0][0] = o_state_c[0][0] ^ rc8_expand(i_rc8);
    end

endmodule

// File: rtl/keccak_perm_ctrl.sv
// Keccak-f[1600] permutation controller: owns the state register and steps
// ROUNDS_PER_CYCLE chained rounds per clock between load and output handshakes.
module keccak_perm_ctrl
    import keccak_pkg::*;
#(
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_xor,
    input  keccak_state_t          in_state,
    input  logic                   clear,
    output logic                   out_valid,
    input  logic                   out_ready,
    output keccak_state_t          out_state,
    output logic                   busy,
    output logic [ROUND_IDX_W-1:0] round_idx
);

    localparam logic [ROUND_IDX_W-1:0] STEP     = ROUND_IDX_W'(ROUNDS_PER_CYCLE);
    localparam logic [ROUND_IDX_W-1:0] LAST_IDX = ROUND_IDX_W'(NUM_ROUNDS - ROUNDS_PER_CYCLE);

    // Only divisors of 24 keep round_idx landing exactly on the last round
    if ((ROUNDS_PER_CYCLE == 0) || (ROUNDS_PER_CYCLE > NUM_ROUNDS) ||
        ((NUM_ROUNDS % ((ROUNDS_PER_CYCLE == 0) ? 1 : ROUNDS_PER_CYCLE)) != 0)) begin : g_bad_rpc
        $error("keccak_perm_ctrl: illegal ROUNDS_PER_CYCLE %0d", ROUNDS_PER_CYCLE);
    end

    keccak_fsm_t            r_fsm;
    keccak_state_t          r_state;
    logic [ROUND_IDX_W-1:0] r_round;
    logic                   r_in_ready;
    logic                   r_busy;
    logic                   r_out_valid;

    keccak_state_t          w_base;
    keccak_state_t          w_load;
    keccak_state_t          w_next;

    for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : g_round
        keccak_state_t    w_in;
        keccak_state_t    w_out;
        logic [RC8_W-1:0] w_rc8;

        if (i == 0) begin : g_first
            assign w_in = r_state;
        end else begin : g_chain
            assign w_in = g_round[i-1].w_out;
        end

        keccak_rc_gen u_rc (
            .i_round (r_round + ROUND_IDX_W'(i)),
            .o_rc8_c (w_rc8)
        );

        keccak_round u_round (
            .i_state   (w_in),
            .i_rc8     (w_rc8),
            .o_state_c (w_out)
        );
    end

    assign w_next = g_round[ROUNDS_PER_CYCLE-1].w_out;

    // clear takes effect before the xor-absorb in the same cycle
    assign w_base = clear ? '0 : r_state;
    assign w_load = in_xor ? (w_base ^ in_state) : in_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= IDLE;
            r_state     <= '0;
            r_round     <= '0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
                        r_state    <= w_load;
                        r_round    <= '0;
                        r_fsm      <= RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end else if (clear) begin
                        r_state <= '0;
                    end
                end
                RUN: begin
                    r_state <= w_next;
                    if (r_round == LAST_IDX) begin
                        r_round     <= '0;
                        r_fsm       <= DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_round <= r_round + STEP;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_fsm       <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_fsm       <= IDLE;
                    r_round     <= '0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready & ~rst;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_state = r_state;
    assign round_idx = r_round;

endmodule

// File: tb/tb_keccak_perm_ctrl.sv
// Directed bench for keccak_perm_ctrl at ROUNDS_PER_CYCLE = 1, 2 and 24.
module tb_keccak_perm_ctrl;
    import keccak_pkg::*;

    localparam int unsigned NDUT = 3;
    localparam logic [63:0] ZERO_PERM_L00 = 64'hF1258F7940E1DDE7;
    localparam logic [63:0] TWICE_PERM_L00 = 64'h2D5C954DF96ECB3C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_xor;
    logic          clear;
    logic          out_ready;
    keccak_state_t in_state;
    logic          in_valid_v  [NDUT];
    logic          in_ready_v  [NDUT];
    logic          out_valid_v [NDUT];
    logic          busy_v      [NDUT];
    keccak_state_t out_state_v [NDUT];
    logic [4:0]    round_idx_v [NDUT];

    int checks = 0;
    int errors = 0;
    logic [7:0] obs [NUM_ROUNDS];

    typedef struct {
        logic        rst;
        logic        clear;
        logic        in_valid;
        logic        in_xor;
        logic [63:0] lane;
        logic        chk_lane;
        logic [63:0] exp_lane;
        logic        exp_busy;
        logic        exp_ready;
        logic [4:0]  exp_round;
    } vec_t;

    typedef struct {
        int unsigned round;
        logic [7:0]  rc8;
    } rc_vec_t;

    vec_t    vecs [10];
    rc_vec_t rcv  [6];

    keccak_perm_ctrl #(.ROUNDS_PER_CYCLE(1)) u_dut_r1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_xor(in_xor), .in_state(in_state), .clear(clear), .out_valid(out_valid_v[0]),
        .out_ready(out_ready), .out_state(out_state_v[0]), .busy(busy_v[0]),
        .round_idx(round_idx_v[0])
    );

    keccak_perm_ctrl #(.ROUNDS_PER_CYCLE(2)) u_dut_r2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_xor(in_xor), .in_state(in_state), .clear(clear), .out_valid(out_valid_v[1]),
        .out_ready(out_ready), .out_state(out_state_v[1]), .busy(busy_v[1]),
        .round_idx(round_idx_v[1])
    );

    keccak_perm_ctrl #(.ROUNDS_PER_CYCLE(24)) u_dut_r24 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .in_xor(in_xor), .in_state(in_state), .clear(clear), .out_valid(out_valid_v[2]),
        .out_ready(out_ready), .out_state(out_state_v[2]), .busy(busy_v[2]),
        .round_idx(round_idx_v[2])
    );

    function automatic vec_t mk(input logic r, input logic c, input logic v, input logic x,
                                input logic [63:0] lane, input logic cl, input logic [63:0] el,
                                input logic eb, input logic er, input logic [4:0] eround);
        vec_t t;
        t.rst = r; t.clear = c; t.in_valid = v; t.in_xor = x; t.lane = lane;
        t.chk_lane = cl; t.exp_lane = el; t.exp_busy = eb; t.exp_ready = er; t.exp_round = eround;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string name, input keccak_state_t act, input keccak_state_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: state differs, lane00 got %h expected %h", name, act[0][0], exp[0][0]);
        end
    endtask

    // Drive one accepted load; returns at the sampling point after the accept edge
    task automatic load(input int d, input logic x, input logic c, input keccak_state_t s);
        in_state      = s;
        in_xor        = x;
        clear         = c;
        in_valid_v[d] = 1'b1;
        @(negedge clk);
        in_valid_v[d] = 1'b0;
        in_xor        = 1'b0;
        clear         = 1'b0;
        in_state      = '0;
    endtask

    task automatic wait_done(input int d, input int exp_cycles, input string name);
        int n  = 0;
        int nb = 0;
        while (out_valid_v[d] !== 1'b1 && n < 100) begin
            if (busy_v[d] === 1'b1) begin
                nb++;
                if (d == 0) begin
                    obs[round_idx_v[0]] = u_dut_r1.g_round[0].w_rc8;
                    chk("rc8_bit2_zero", 64'(u_dut_r1.g_round[0].w_rc8[2]), 64'd0);
                end
            end
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, 64'(n), 64'(exp_cycles));
        chk({name, "_busy_cycles"}, 64'(nb), 64'(exp_cycles));
    endtask

    task automatic chk_done(input int d, input logic [63:0] exp_lane, input string name);
        chk({name, "_lane00"}, out_state_v[d][0][0], exp_lane);
        chk({name, "_round_idx"}, 64'(round_idx_v[d]), 64'd0);
        chk({name, "_in_ready"}, 64'(in_ready_v[d]), 64'd0);
        chk({name, "_busy"}, 64'(busy_v[d]), 64'd0);
    endtask

    task automatic handshake(input int d, input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_hs_out_valid"}, 64'(out_valid_v[d]), 64'd0);
        chk({name, "_hs_in_ready"}, 64'(in_ready_v[d]), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        keccak_state_t z_state;
        keccak_state_t y_state;
        keccak_state_t zero_state;
        zero_state = '0;

        vecs[0] = mk(1, 0, 0, 0, 64'h0,                1, 64'h0,                0, 0, 5'd0);
        vecs[1] = mk(0, 0, 1, 0, 64'hA5A5A5A5A5A5A5A5, 1, 64'hA5A5A5A5A5A5A5A5, 1, 0, 5'd0);
        vecs[2] = mk(1, 0, 0, 0, 64'h0,                1, 64'h0,                0, 0, 5'd0);
        vecs[3] = mk(0, 1, 0, 0, 64'h0,                1, 64'h0,                0, 1, 5'd0);
        vecs[4] = mk(0, 0, 1, 1, 64'h0123456789ABCDEF, 1, 64'h0123456789ABCDEF, 1, 0, 5'd0);
        vecs[5] = mk(0, 1, 1, 0, 64'hFFFFFFFFFFFFFFFF, 0, 64'h0,                1, 0, 5'd1);
        vecs[6] = mk(0, 0, 0, 0, 64'h0,                0, 64'h0,                1, 0, 5'd2);
        vecs[7] = mk(1, 0, 0, 0, 64'h0,                1, 64'h0,                0, 0, 5'd0);
        vecs[8] = mk(0, 1, 1, 1, 64'hFEDCBA9876543210, 1, 64'hFEDCBA9876543210, 1, 0, 5'd0);
        vecs[9] = mk(1, 0, 0, 0, 64'h0,                1, 64'h0,                0, 0, 5'd0);

        rcv[0] = '{0, 8'h01};
        rcv[1] = '{1, 8'h32};
        rcv[2] = '{2, 8'hBA};
        rcv[3] = '{3, 8'hE0};
        rcv[4] = '{12, 8'h7B};
        rcv[5] = '{23, 8'hE8};

        for (int i = 0; i < NUM_ROUNDS; i++) obs[i] = 8'h00;
        rst = 1'b1; in_xor = 1'b0; clear = 1'b0; out_ready = 1'b0; in_state = '0;
        for (int i = 0; i < int'(NDUT); i++) in_valid_v[i] = 1'b0;
        repeat (2) @(negedge clk);

        // Single-cycle control vectors on the R=1 instance
        for (int i = 0; i < 10; i++) begin
            rst           = vecs[i].rst;
            clear         = vecs[i].clear;
            in_valid_v[0] = vecs[i].in_valid;
            in_xor        = vecs[i].in_xor;
            in_state      = '0;
            in_state[0][0] = vecs[i].lane;
            @(negedge clk);
            if (vecs[i].chk_lane) chk($sformatf("vec%0d_lane", i), out_state_v[0][0][0], vecs[i].exp_lane);
            chk($sformatf("vec%0d_busy", i), 64'(busy_v[0]), 64'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_in_ready", i), 64'(in_ready_v[0]), 64'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_round_idx", i), 64'(round_idx_v[0]), 64'(vecs[i].exp_round));
        end
        rst = 1'b0; clear = 1'b0; in_valid_v[0] = 1'b0; in_xor = 1'b0; in_state = '0;
        @(negedge clk);
        chk("post_reset_in_ready", 64'(in_ready_v[0]), 64'd1);
        chk("post_reset_out_valid", 64'(out_valid_v[0]), 64'd0);

        // Zero state through 24 rounds, probing the round constants
        load(0, 1'b0, 1'b0, zero_state);
        wait_done(0, 24, "r1_zero");
        chk_done(0, ZERO_PERM_L00, "r1_zero");
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rc8_round%0d", rcv[i].round), 64'(obs[rcv[i].round]), 64'(rcv[i].rc8));
        end
        z_state = out_state_v[0];

        // DONE holds under back-pressure and ignores loads
        for (int i = 0; i < 10; i++) begin
            in_valid_v[0] = (i % 2 == 0);
            @(negedge clk);
            chk("hold_out_valid", 64'(out_valid_v[0]), 64'd1);
            chk("hold_in_ready", 64'(in_ready_v[0]), 64'd0);
            chk_state("hold_state", out_state_v[0], z_state);
        end
        in_valid_v[0] = 1'b0;
        handshake(0, "r1_zero");
        chk_state("retained_state", out_state_v[0], z_state);

        // clear in IDLE, then xor-absorb onto the cleared state
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk_state("idle_clear", out_state_v[0], zero_state);
        load(0, 1'b1, 1'b0, z_state);
        chk_state("xor_onto_cleared", out_state_v[0], z_state);
        wait_done(0, 24, "r1_twice");
        chk_done(0, TWICE_PERM_L00, "r1_twice");
        y_state = out_state_v[0];
        handshake(0, "r1_twice");

        // clear and xor-absorb in the same cycle: clear wins as the base
        load(0, 1'b1, 1'b1, z_state);
        chk_state("clear_xor_same_cycle", out_state_v[0], z_state);
        wait_done(0, 24, "r1_clrxor");
        chk_done(0, TWICE_PERM_L00, "r1_clrxor");
        handshake(0, "r1_clrxor");

        // xor the retained state with itself: back to zero, then the zero permutation
        load(0, 1'b1, 1'b0, y_state);
        chk_state("xor_self_zero", out_state_v[0], zero_state);
        wait_done(0, 24, "r1_self");
        chk_done(0, ZERO_PERM_L00, "r1_self");
        handshake(0, "r1_self");

        // Reset in the middle of a run
        load(0, 1'b0, 1'b0, zero_state);
        repeat (7) @(negedge clk);
        chk("midrun_round_idx", 64'(round_idx_v[0]), 64'd7);
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_rst_in_ready", 64'(in_ready_v[0]), 64'd0);
        rst = 1'b0;
        #1;
        chk("midrun_busy", 64'(busy_v[0]), 64'd0);
        chk("midrun_out_valid", 64'(out_valid_v[0]), 64'd0);
        chk("midrun_round", 64'(round_idx_v[0]), 64'd0);
        chk("midrun_in_ready", 64'(in_ready_v[0]), 64'd1);
        chk_state("midrun_state", out_state_v[0], zero_state);
        @(negedge clk);
        load(0, 1'b0, 1'b0, zero_state);
        wait_done(0, 24, "r1_after_rst");
        chk_done(0, ZERO_PERM_L00, "r1_after_rst");
        handshake(0, "r1_after_rst");

        // Multi-round-per-cycle instances
        load(1, 1'b0, 1'b0, zero_state);
        wait_done(1, 12, "r2_zero");
        chk_done(1, ZERO_PERM_L00, "r2_zero");
        load(2, 1'b0, 1'b0, zero_state);
        wait_done(2, 1, "r24_zero");
        chk_done(2, ZERO_PERM_L00, "r24_zero");
        chk_state("r2_matches_r1", out_state_v[1], z_state);
        chk_state("r24_matches_r1", out_state_v[2], z_state);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
